// File: rtl/lockout_digital_lock_pkg.sv
// Shared definitions for the lockout digital lock: state encoding, display
// codes and the key-digit width helper.
package lockout_digital_lock_pkg;

    typedef enum logic [2:0] {
        ST_UNLOCKED = 3'd0,
        ST_CREATE   = 3'd1,
        ST_CONFIRM  = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_ENTER    = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_e;

    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [3:0] LOCK  = 4'hE;

    function automatic int dw_f(input int num_keys);
        return (num_keys <= 2) ? 1 : $clog2(num_keys);
    endfunction

endpackage

// File: rtl/lockout_digital_lock_key_onehot_encoder.sv
// Turns the raw key pulse vector into {valid, digit}; only a vector with
// exactly one bit high is a valid press.
module key_onehot_encoder
    import lockout_digital_lock_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int DW       = dw_f(NUM_KEYS)
) (
    input  logic [NUM_KEYS-1:0] key,
    output logic                valid,
    output logic [DW-1:0]       digit
);

    logic [4:0] ones_s;

    // Population count plus index of the (last) high bit.
    always_comb begin
        ones_s = 5'd0;
        digit  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            ones_s = ones_s + {4'd0, key[i]};
            digit  = key[i] ? DW'(i) : digit;
        end
        valid = (ones_s == 5'd1);
    end

endmodule

// File: rtl/lockout_digital_lock.sv
// Password lock with create/confirm, entry, attempt counting, timed lockout
// and an idle abort timer; all outputs are registered.
module lockout_digital_lock
    import lockout_digital_lock_pkg::*;
#(
    parameter int PASSWORD_LENGTH = 4,
    parameter int NUM_KEYS        = 4,
    parameter int NUM_DISPLAYS    = 6,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_CYCLES  = 50000000,
    parameter int ENTRY_TIMEOUT   = 250000000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_KEYS-1:0]       key,
    output logic                      lock_flag,
    output logic                      error_flag,
    output logic                      enter_pwd_flag,
    output logic                      create_pwd_flag,
    output logic                      lockout_flag,
    output logic [3:0]                attempts_left,
    output logic [4*NUM_DISPLAYS-1:0] display_digits
);

    localparam int              DW           = dw_f(NUM_KEYS);
    localparam int              IW           = $clog2(PASSWORD_LENGTH + 1);
    localparam logic [IW-1:0]   LAST_IDX     = IW'(PASSWORD_LENGTH - 1);
    localparam logic [31:0]     LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [31:0]     IDLE_LOAD    = 32'(ENTRY_TIMEOUT - 1);
    localparam logic [3:0]      MAX_FAILS    = 4'(MAX_ATTEMPTS);

    typedef logic [PASSWORD_LENGTH-1:0][DW-1:0] code_t;

    state_e                   state_q, state_d, eff_state_s;
    logic [IW-1:0]            idx_q, idx_d, eff_idx_s;
    code_t                    entry_q, entry_d, cand_q, cand_d, pwd_q, pwd_d;
    logic [3:0]               fail_q, fail_d, fail_inc_s;
    logic [31:0]              lock_cnt_q, lock_cnt_d, idle_q, idle_d;
    logic                     valid_s, err_s, in_entry_s;
    logic [DW-1:0]            digit_s;
    logic [NUM_DISPLAYS-1:0][DW-1:0] shown_s;

    logic                      lock_flag_q, lock_flag_d;
    logic                      error_flag_q, error_flag_d;
    logic                      enter_flag_q, enter_flag_d;
    logic                      create_flag_q, create_flag_d;
    logic                      lockout_flag_q, lockout_flag_d;
    logic [3:0]                attempts_q, attempts_d;
    logic [4*NUM_DISPLAYS-1:0] display_q, display_d;

    key_onehot_encoder #(
        .NUM_KEYS (NUM_KEYS),
        .DW       (DW)
    ) u_encoder (
        .key   (key),
        .valid (valid_s),
        .digit (digit_s)
    );

    // Next-state logic: presses, completion compares, lockout countdown, idle abort.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        entry_d    = entry_q;
        cand_d     = cand_q;
        pwd_d      = pwd_q;
        fail_d     = fail_q;
        lock_cnt_d = lock_cnt_q;
        idle_d     = idle_q;
        err_s      = 1'b0;
        fail_inc_s = (fail_q >= MAX_FAILS) ? MAX_FAILS : (fail_q + 4'd1);
        in_entry_s = (state_q == ST_CREATE) || (state_q == ST_CONFIRM) || (state_q == ST_ENTER);

        // A first press from a resting state behaves as digit 0 of the entry state.
        case (state_q)
            ST_UNLOCKED: begin
                eff_state_s = ST_CREATE;
                eff_idx_s   = '0;
            end
            ST_LOCKED: begin
                eff_state_s = ST_ENTER;
                eff_idx_s   = '0;
            end
            default: begin
                eff_state_s = state_q;
                eff_idx_s   = idx_q;
            end
        endcase

        if (state_q == ST_LOCKOUT) begin
            if (lock_cnt_q == 32'd0) begin
                state_d = ST_LOCKED;
                fail_d  = 4'd0;
            end else begin
                lock_cnt_d = lock_cnt_q - 32'd1;
            end
        end else if (valid_s) begin
            for (int i = 0; i < PASSWORD_LENGTH; i++) begin
                entry_d[i] = (i == int'(eff_idx_s)) ? digit_s : entry_q[i];
            end
            state_d = eff_state_s;
            if (eff_idx_s == LAST_IDX) begin
                idx_d = '0;
                case (eff_state_s)
                    ST_CREATE: begin
                        cand_d  = entry_d;
                        state_d = ST_CONFIRM;
                    end
                    ST_CONFIRM: begin
                        if (entry_d == cand_q) begin
                            pwd_d   = entry_d;
                            fail_d  = 4'd0;
                            state_d = ST_LOCKED;
                        end else begin
                            err_s   = 1'b1;
                            state_d = ST_UNLOCKED;
                        end
                    end
                    ST_ENTER: begin
                        if (entry_d == pwd_q) begin
                            fail_d  = 4'd0;
                            state_d = ST_UNLOCKED;
                        end else begin
                            err_s   = 1'b1;
                            fail_d  = fail_inc_s;
                            state_d = (fail_inc_s == MAX_FAILS) ? ST_LOCKOUT : ST_LOCKED;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end else begin
                idx_d = eff_idx_s + IW'(1);
            end
        end else if (in_entry_s && (idle_q == 32'd0)) begin
            err_s   = 1'b1;
            idx_d   = '0;
            state_d = (state_q == ST_ENTER) ? ST_LOCKED : ST_UNLOCKED;
        end else begin
            state_d = state_q;
        end

        if ((state_d == ST_LOCKOUT) && (state_q != ST_LOCKOUT)) begin
            lock_cnt_d = LOCKOUT_LOAD;
        end else begin
            lock_cnt_d = lock_cnt_d;
        end

        if ((state_d != state_q) || valid_s) begin
            idle_d = IDLE_LOAD;
        end else if (in_entry_s && (idle_q != 32'd0)) begin
            idle_d = idle_q - 32'd1;
        end else begin
            idle_d = idle_q;
        end
    end

    // Output values derived from the next state so the registers track it with one cycle latency.
    always_comb begin
        shown_s = '0;
        for (int i = 0; i < PASSWORD_LENGTH; i++) begin
            shown_s[i] = entry_d[i];
        end
        lock_flag_d    = (state_d == ST_LOCKED) || (state_d == ST_ENTER) || (state_d == ST_LOCKOUT);
        error_flag_d   = err_s;
        enter_flag_d   = (state_d == ST_ENTER);
        create_flag_d  = (state_d == ST_CREATE) || (state_d == ST_CONFIRM);
        lockout_flag_d = (state_d == ST_LOCKOUT);
        attempts_d     = MAX_FAILS - fail_d;
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            if (state_d == ST_LOCKOUT) begin
                display_d[4*i +: 4] = LOCK;
            end else if (i < int'(idx_d)) begin
                display_d[4*i +: 4] = 4'(shown_s[i]);
            end else begin
                display_d[4*i +: 4] = BLANK;
            end
        end
    end

    // State, storage, timers and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_UNLOCKED;
            idx_q          <= '0;
            entry_q        <= '0;
            cand_q         <= '0;
            pwd_q          <= '0;
            fail_q         <= 4'd0;
            lock_cnt_q     <= 32'd0;
            idle_q         <= 32'd0;
            lock_flag_q    <= 1'b0;
            error_flag_q   <= 1'b0;
            enter_flag_q   <= 1'b0;
            create_flag_q  <= 1'b0;
            lockout_flag_q <= 1'b0;
            attempts_q     <= MAX_FAILS;
            display_q      <= {NUM_DISPLAYS{BLANK}};
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            entry_q        <= entry_d;
            cand_q         <= cand_d;
            pwd_q          <= pwd_d;
            fail_q         <= fail_d;
            lock_cnt_q     <= lock_cnt_d;
            idle_q         <= idle_d;
            lock_flag_q    <= lock_flag_d;
            error_flag_q   <= error_flag_d;
            enter_flag_q   <= enter_flag_d;
            create_flag_q  <= create_flag_d;
            lockout_flag_q <= lockout_flag_d;
            attempts_q     <= attempts_d;
            display_q      <= display_d;
        end
    end

    assign lock_flag       = lock_flag_q;
    assign error_flag      = error_flag_q;
    assign enter_pwd_flag  = enter_flag_q;
    assign create_pwd_flag = create_flag_q;
    assign lockout_flag    = lockout_flag_q;
    assign attempts_left   = attempts_q;
    assign display_digits  = display_q;

endmodule

// File: tb/tb_lockout_digital_lock.sv
// Scoreboard bench: stimulus queues expected output snapshots, a monitor
// compares them whenever the flag/attempt outputs change or a probe is requested.
module tb_lockout_digital_lock;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  key   = 4'd0;
    logic        lock_flag, error_flag, enter_pwd_flag, create_pwd_flag, lockout_flag;
    logic [3:0]  attempts_left;
    logic [23:0] display_digits;

    typedef struct {
        string       name;
        logic [4:0]  flags;   // {lock, error, enter, create, lockout}
        logic [3:0]  att;
        logic [23:0] disp;
        int          gap;     // cycles since previous output change, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   probe_cnt = 0;
    bit   mon_en    = 1'b0;

    lockout_digital_lock #(
        .PASSWORD_LENGTH (4),
        .NUM_KEYS        (4),
        .NUM_DISPLAYS    (6),
        .MAX_ATTEMPTS    (3),
        .LOCKOUT_CYCLES  (20),
        .ENTRY_TIMEOUT   (10)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .key             (key),
        .lock_flag       (lock_flag),
        .error_flag      (error_flag),
        .enter_pwd_flag  (enter_pwd_flag),
        .create_pwd_flag (create_pwd_flag),
        .lockout_flag    (lockout_flag),
        .attempts_left   (attempts_left),
        .display_digits  (display_digits)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic expect_out(input string name, input logic [4:0] flags,
                              input logic [3:0] att, input logic [23:0] disp, input int gap);
        exp_t e;
        e.name = name; e.flags = flags; e.att = att; e.disp = disp; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clock) key = k;
        @(negedge clock) key = 4'd0;
    endtask

    task automatic probe();
        @(posedge clock);
        probe_cnt = probe_cnt + 1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: one comparison per output change or probe request.
    initial begin : monitor
        exp_t       e;
        logic [8:0] cur, prev;
        int         seen, last;
        bit         is_evt;
        seen = 0; last = 0; prev = '0;
        forever begin
            @(negedge clock);
            cur = {lock_flag, error_flag, enter_pwd_flag, create_pwd_flag, lockout_flag, attempts_left};
            if (mon_en && ((cur !== prev) || (probe_cnt != seen))) begin
                is_evt = (cur !== prev);
                seen   = probe_cnt;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got flags/att=%h disp=%h required none", cur, display_digits);
                end else begin
                    e = exp_q.pop_front();
                    if (({e.flags, e.att} !== cur) || (e.disp !== display_digits) ||
                        ((e.gap >= 0) && ((cyc - last) != e.gap))) begin
                        errors++;
                        $display("FAIL %s got flags=%b att=%0d disp=%h gap=%0d required flags=%b att=%0d disp=%h gap=%0d",
                                 e.name, cur[8:4], cur[3:0], display_digits, cyc - last,
                                 e.flags, e.att, e.disp, e.gap);
                    end
                end
                if (is_evt) last = cyc;
            end
            prev = cur;
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;
        expect_out("reset_state", 5'b00000, 4'd3, 24'hFFFFFF, -1);
        probe();

        // Create 1230 and confirm it.
        expect_out("create_start", 5'b00010, 4'd3, 24'hFFFFF1, -1);
        expect_out("confirm_mid", 5'b00010, 4'd3, 24'hFFFF21, -1);
        expect_out("confirm_locked", 5'b10000, 4'd3, 24'hFFFFFF, -1);
        press(4'b0010); press(4'b0100); press(4'b1000); press(4'b0001);
        press(4'b0010); press(4'b0100);
        probe();
        press(4'b1000); press(4'b0001);
        drain("create", 50);

        // Wrong code 2000 with an ignored multi-key press inside it.
        expect_out("enter_start", 5'b10100, 4'd3, 24'hFFFFF2, -1);
        expect_out("ignored_multi", 5'b10100, 4'd3, 24'hFFFFF2, -1);
        expect_out("wrong1_err", 5'b11000, 4'd2, 24'hFFFFFF, -1);
        expect_out("wrong1_end", 5'b10000, 4'd2, 24'hFFFFFF, 1);
        press(4'b0100); press(4'b0110);
        probe();
        press(4'b0001); press(4'b0001); press(4'b0001);
        drain("wrong1", 50);

        // Wrong code 3333.
        expect_out("wrong2_start", 5'b10100, 4'd2, 24'hFFFFF3, -1);
        expect_out("wrong2_err", 5'b11000, 4'd1, 24'hFFFFFF, -1);
        expect_out("wrong2_end", 5'b10000, 4'd1, 24'hFFFFFF, 1);
        repeat (4) press(4'b1000);
        drain("wrong2", 50);

        // Wrong code 0001 triggers a 20-cycle lockout; keys inside it are ignored.
        expect_out("wrong3_start", 5'b10100, 4'd1, 24'hFFFFF0, -1);
        expect_out("lockout_err", 5'b11001, 4'd0, 24'hEEEEEE, -1);
        expect_out("lockout_hold", 5'b10001, 4'd0, 24'hEEEEEE, 1);
        expect_out("lockout_exit", 5'b10000, 4'd3, 24'hFFFFFF, 19);
        press(4'b0001); press(4'b0001); press(4'b0001); press(4'b0010);
        press(4'b0010); press(4'b1111); press(4'b0100);
        drain("lockout", 80);

        // Two digits then idle: abort back to LOCKED, fail count untouched.
        expect_out("timeout_start", 5'b10100, 4'd3, 24'hFFFFF1, -1);
        expect_out("timeout_err", 5'b11000, 4'd3, 24'hFFFFFF, 12);
        expect_out("timeout_end", 5'b10000, 4'd3, 24'hFFFFFF, 1);
        press(4'b0010); press(4'b0100);
        drain("timeout", 40);

        // Correct code unlocks one cycle after the 4th press.
        expect_out("unlock_start", 5'b10100, 4'd3, 24'hFFFFF1, -1);
        expect_out("unlocked", 5'b00000, 4'd3, 24'hFFFFFF, 6);
        press(4'b0010); press(4'b0100); press(4'b1000); press(4'b0001);
        drain("unlock", 40);

        // Reset in the middle of CONFIRM, then a fresh create starts at index 0.
        expect_out("create2_start", 5'b00010, 4'd3, 24'hFFFFF2, -1);
        expect_out("confirm2_mid", 5'b00010, 4'd3, 24'hFFFFF1, -1);
        expect_out("reset_mid", 5'b00000, 4'd3, 24'hFFFFFF, -1);
        expect_out("create3_start", 5'b00010, 4'd3, 24'hFFFFF3, -1);
        repeat (4) press(4'b0100);
        press(4'b0010);
        probe();
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        @(negedge clock) reset = 1'b1;
        press(4'b1000);
        drain("reset_mid", 40);

        repeat (5) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
